yuv_enhance_ctrl: RTL

- Per-frame automatic controller for the luma enhancement controls of the RGB-to-YUV converter.
- Accumulates luma over active pixels and computes the frame mean with a sequential 8-step divider at the vertical-sync edge.
- Applies hysteresis thresholds to that mean and drives the darkup/lightdown switch and threshold controls.
- Control updates occur only at frame boundaries, never mid-frame; a manual override path lets the host force the values.

---
 rtl/yuv_enhance_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/yuv_enhance_ctrl.sv
// Per-frame luma statistics and hysteresis controller for the converter's
// darkup/lightdown enhancement controls; updates land only at frame boundaries.
module yuv_enhance_ctrl #(
    parameter int unsigned CNT_W      = 22,
    parameter bit          VS_POL     = 1'b1,
    parameter int unsigned DARK_ON    = 64,
    parameter int unsigned DARK_OFF   = 80,
    parameter int unsigned BRIGHT_ON  = 192,
    parameter int unsigned BRIGHT_OFF = 176,
    parameter int unsigned DARK_NUM   = 96,
    parameter int unsigned BRIGHT_NUM = 160
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] y_in,
    input  logic       vs_in,
    input  logic       de_in,
    input  logic       manual_en,
    input  logic [7:0] manual_darkup_num,
    input  logic       manual_darkup_sw,
    input  logic [7:0] manual_lightdown_num,
    input  logic       manual_lightdown_sw,
    output logic [7:0] video_enhance_darkup_num,
    output logic       video_enhance_darkup_sw,
    output logic [7:0] video_enhance_lightdown_num,
    output logic       video_enhance_lightdown_sw,
    output logic [7:0] mean_luma,
    output logic       stat_valid,
    output logic       busy
);

    localparam int unsigned      SUM_W        = CNT_W + 8;
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [7:0]       DARK_ON_C    = 8'(DARK_ON);
    localparam logic [7:0]       DARK_OFF_C   = 8'(DARK_OFF);
    localparam logic [7:0]       BRIGHT_ON_C  = 8'(BRIGHT_ON);
    localparam logic [7:0]       BRIGHT_OFF_C = 8'(BRIGHT_OFF);
    localparam logic [7:0]       DARK_NUM_C   = 8'(DARK_NUM);
    localparam logic [7:0]       BRIGHT_NUM_C = 8'(BRIGHT_NUM);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_DECIDE
    } state_t;

    state_t state_q, state_d;

    logic             vs_act;
    logic             vs_prev_q;
    logic             frame_edge;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_q;

    logic [SUM_W-1:0] rem_q;
    logic [SUM_W-1:0] dvs_q;
    logic [7:0]       quot_q;
    logic [2:0]       step_q;
    logic             valid_q;
    logic             rem_ge;

    logic             load;
    logic             div_step;
    logic             decide;
    logic             dark_q, dark_d;
    logic             bright_q, bright_d;

    logic [7:0]       dn_num_q, ld_num_q, mean_q;
    logic             dn_sw_q, ld_sw_q, stat_q;

    assign vs_act     = (vs_in == VS_POL);
    assign frame_edge = vs_act && !vs_prev_q;
    assign rem_ge     = (rem_q >= dvs_q);

    // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        sum_d = sum_q;
        cnt_d = cnt_q;
        if (frame_edge) begin
            sum_d = de_in ? SUM_W'(y_in) : '0;
            cnt_d = de_in ? CNT_W'(1) : '0;
        end else if (de_in && (cnt_q != CNT_MAX)) begin
            sum_d = sum_q + SUM_W'(y_in);
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Empty frames take the same DIV path (result unused) so control latency never varies.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (frame_edge && !first_q) state_d = S_DIV;
            S_DIV:    if (step_q == 3'd0) state_d = S_DECIDE;
            S_DECIDE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        load     = (state_q == S_IDLE) && frame_edge && !first_q;
        div_step = (state_q == S_DIV);
        decide   = (state_q == S_DECIDE);
    end

    always_comb begin
        dark_d   = dark_q;
        bright_d = bright_q;
        if (valid_q) begin
            if (quot_q < DARK_ON_C)         dark_d = 1'b1;
            else if (quot_q >= DARK_OFF_C)  dark_d = 1'b0;
            if (quot_q > BRIGHT_ON_C)       bright_d = 1'b1;
            else if (quot_q <= BRIGHT_OFF_C) bright_d = 1'b0;
        end
    end

    // NOTE: divider scratch registers carry no reset; they are always loaded before being read.
    always_ff @(posedge clk) begin
        if (load) begin
            rem_q   <= sum_q;
            dvs_q   <= SUM_W'(cnt_q) << 7;
            quot_q  <= '0;
            step_q  <= 3'd7;
            valid_q <= (cnt_q != '0);
        end else if (div_step) begin
            if (rem_ge) rem_q <= rem_q - dvs_q;
            dvs_q  <= dvs_q >> 1;
            quot_q <= {quot_q[6:0], rem_ge};
            step_q <= step_q - 3'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            vs_prev_q <= 1'b1;
            sum_q     <= '0;
            cnt_q     <= '0;
            first_q   <= 1'b1;
            dark_q    <= 1'b0;
            bright_q  <= 1'b0;
            dn_num_q  <= DARK_NUM_C;
            dn_sw_q   <= 1'b0;
            ld_num_q  <= BRIGHT_NUM_C;
            ld_sw_q   <= 1'b0;
            mean_q    <= '0;
            stat_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vs_prev_q <= vs_act;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            stat_q    <= 1'b0;
            if ((state_q == S_IDLE) && frame_edge) first_q <= 1'b0;
            if (decide) begin
                dark_q   <= dark_d;
                bright_q <= bright_d;
                if (valid_q) begin
                    mean_q <= quot_q;
                    stat_q <= 1'b1;
                end
                if (manual_en) begin
                    dn_num_q <= manual_darkup_num;
                    dn_sw_q  <= manual_darkup_sw;
                    ld_num_q <= manual_lightdown_num;
                    ld_sw_q  <= manual_lightdown_sw;
                end else begin
                    dn_num_q <= DARK_NUM_C;
                    dn_sw_q  <= dark_d;
                    ld_num_q <= BRIGHT_NUM_C;
                    ld_sw_q  <= bright_d;
                end
            end
        end
    end

    assign video_enhance_darkup_num    = dn_num_q;
    assign video_enhance_darkup_sw     = dn_sw_q;
    assign video_enhance_lightdown_num = ld_num_q;
    assign video_enhance_lightdown_sw  = ld_sw_q;
    assign mean_luma                   = mean_q;
    assign stat_valid                  = stat_q;

endmodule
